ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0001_0000, byte base address of the memory window.
REQ-002 Parameter DEPTH_WORDS, default 16384, number of 32-bit words (power of two).
REQ-003 Parameter WAIT_STATES, default 0, range 0..7, hready-low cycles inserted at start of every OKAY data phase.
REQ-004 clk  input  1  sole clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ahb_if_hsel  input  1  slave select.
REQ-007 ahb_if_haddr  input  32  byte address.
REQ-008 ahb_if_hwrite  input  1  1=write, 0=read.
REQ-009 ahb_if_hwdata  input  32  write data, data phase.
REQ-010 ahb_if_htrans  input  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-011 ahb_if_hsize  input  3  transfer size.
REQ-012 ahb_if_hburst  input  3  burst type, beats handled individually.
REQ-013 ahb_if_hreadyin  input  1  bus-level ready (see REQ-031).
REQ-014 ahb_if_hready  output  1  data phase complete.
REQ-015 ahb_if_hrdata  output  32  read data.
REQ-016 ahb_if_hresp  output  2  00=OKAY, 01=ERROR.

Function
REQ-017 Address phase accepted on a posedge where hsel=1, htrans[1]=1 and hready=1 (ahb_if_hready output); captures haddr, hwrite, hsize.
REQ-018 Accepted transfer errors when address is outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS), hsize>3'b010, or haddr is misaligned to hsize.
REQ-019 FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
REQ-020 IDLE: hready=1, hresp=OKAY; a valid accept moves to ERR1 if erroring, else WAIT when wait count>0, else LAST.
REQ-021 WAIT: hready=0, hresp=OKAY, down-counter from WAIT_STATES (plus REQ-025 stall); moves to LAST when the count reaches 0.
REQ-022 LAST: hready=1, hresp=OKAY; the transfer completes; a new accept in this cycle follows REQ-020, otherwise the FSM returns to IDLE.
REQ-023 ERR1: hready=0, hresp=ERROR; ERR2: hready=1, hresp=ERROR; no memory access; an accept in ERR2 follows REQ-020.
REQ-024 Writes: memory updated at the LAST posedge using hwdata lanes selected by haddr[1:0] and hsize (byte/half/word strobes); untouched lanes keep their value.
REQ-025 Reads: memory read is synchronous; the read address is issued at accept. When the accept coincides with a write LAST, one extra wait cycle is inserted, and the read returns the newly written data.
REQ-026 hrdata carries the full addressed word in a read LAST cycle and is 0 in all other cycles.
REQ-027 IDLE/BUSY htrans with hsel=1, or hsel=0, yields a zero-wait OKAY with no memory access.
REQ-028 Back-to-back NONSEQ/SEQ beats with WAIT_STATES=0 and no conflict sustain one transfer per cycle.

Reset
REQ-029 While rst=1: FSM=IDLE, counter=0, hready=1, hresp=OKAY, hrdata=0, captured controls cleared.
REQ-030 Reset mid-transfer abandons the transfer without a memory write; memory contents are not reset.

Configuration
REQ-031 With AHB_SRAM_HREADYIN_EN defined, acceptance additionally requires ahb_if_hreadyin=1 (multi-slave bus). Without it, hreadyin is ignored and the block's own hready gates acceptance (point-to-point, since the loader ties hreadyin low).

Structure
REQ-032 Package ahb_pkg holds the htrans enum (IDLE/BUSY/NONSEQ/SEQ), the hsize encodings, the hresp encodings and the FSM state typedef.
REQ-033 Storage is a sub-module ahb_sram_mem: single-port DEPTH_WORDS x 32 memory with 4-bit byte write enable and a synchronous read.

Verification
REQ-034 Word write 32'hDEADBEEF to 32'h0001_0000, then read it back, WAIT_STATES=0 -> each data phase 1 cycle, hrdata=32'hDEADBEEF, hresp=OKAY.
REQ-035 WAIT_STATES=3, read 32'h0001_0004 -> hready low exactly 3 cycles, then high with data.
REQ-036 Byte write 8'hA5 to 32'h0001_0002 over a word of 32'h11223344 -> readback 32'h11A53344.
REQ-037 Read 32'h0002_0000 (out of range), and word access at 32'h0001_0001 -> each gives ERR1 (hready=0, ERROR) then ERR2 (hready=1, ERROR); memory unchanged.
REQ-038 Write 32'h5 to 32'h0001_0010 with a pipelined read of the same address -> one inserted wait, read returns 32'h5.
REQ-039 rst asserted during WAIT of a write -> next cycle hready=1, hresp=OKAY, target word unchanged; with AHB_SRAM_HREADYIN_EN, hreadyin=0 -> no transfer accepted.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM slave FSM state type.
// Imported by the slave, its interface users and the bench.
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_e;

   function automatic logic [3:0] lane_strobe(
      input logic [2:0] size,
      input logic [1:0] lane
   );
      case (size)
         HSIZE_BYTE: return 4'b0001 << lane;
         HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(
      input logic [2:0] size,
      input logic [1:0] lane
   );
      return (size == HSIZE_HALF && lane[0]) ||
             (size == HSIZE_WORD && lane != 2'b00);
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus bundle between a master and the SRAM slave.
// hreadyin is the shared bus ready seen by every slave.
interface ahb_sram_slave_if;

   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hreadyin;
   logic        hready;
   logic [31:0] hrdata;
   logic [1:0]  hresp;

   modport master (
      output hsel, haddr, hwrite, hwdata,
      output htrans, hsize, hburst, hreadyin,
      input  hready, hrdata, hresp
   );

   modport slave (
      input  hsel, haddr, hwrite, hwdata,
      input  htrans, hsize, hburst, hreadyin,
      output hready, hrdata, hresp
   );

endinterface

// File: rtl/ahb_sram_mem.sv
// Single-port word memory with byte write enables.
// A write cycle does not read; contents are never reset.
module ahb_sram_mem #(
   parameter int DEPTH_WORDS = 16384,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (|we) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave with programmable wait states.
// Define AHB_SRAM_HREADYIN_EN to qualify accepts with hreadyin.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
   parameter int          DEPTH_WORDS = 16384,
   parameter int          WAIT_STATES = 0
) (
   input logic             clk,
   input logic             rst,
   ahb_sram_slave_if.slave ahb_if
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT =
      {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d, waits, we;
   logic [AW-1:0] idx_q, mem_addr;
   logic [1:0]    lane_q;
   logic [2:0]    size_q;
   logic          wr_q, rdy, acc, bad;
   logic          wr_now, conflict;
   logic [31:0]   off, rd_data;

   assign off = ahb_if.haddr - ADDR_BASE;

   assign bad = ahb_if.haddr < ADDR_BASE ||
                {1'b0, ahb_if.haddr} >= LIMIT ||
                ahb_if.hsize > HSIZE_WORD ||
                misaligned(ahb_if.hsize, ahb_if.haddr[1:0]);

   assign rdy = rst || state_q == ST_IDLE ||
                state_q == ST_LAST || state_q == ST_ERR2;

`ifdef AHB_SRAM_HREADYIN_EN
   assign acc = !rst && ahb_if.hsel && ahb_if.htrans[1] &&
                rdy && ahb_if.hreadyin;
   wire unused_ok = ^{ahb_if.hburst, off[31:AW+2], off[1:0]};
`else
   assign acc = !rst && ahb_if.hsel && ahb_if.htrans[1] && rdy;
   wire unused_ok = ^{ahb_if.hburst, ahb_if.hreadyin,
                      off[31:AW+2], off[1:0]};
`endif

   // The port is busy writing, so a read accepted now is reissued later
   assign wr_now   = !rst && state_q == ST_LAST && wr_q;
   assign conflict = wr_now && !ahb_if.hwrite;
   assign waits    = WS + {3'b000, conflict};

   assign we       = wr_now ? lane_strobe(size_q, lane_q) : 4'b0000;
   assign mem_addr = (acc && !wr_now) ? off[AW+1:2] : idx_q;

   ahb_sram_mem #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_mem (
      .clk  (clk),
      .we   (we),
      .addr (mem_addr),
      .wdata(ahb_if.hwdata),
      .rdata(rd_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_LAST;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (acc) begin
               priority case (1'b1)
                  bad: state_d = ST_ERR1;
                  (waits != 4'd0): begin
                     state_d = ST_WAIT;
                     cnt_d   = waits - 4'd1;
                  end
                  default: state_d = ST_LAST;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (acc) begin
            idx_q  <= off[AW+1:2];
            lane_q <= ahb_if.haddr[1:0];
            size_q <= ahb_if.hsize;
            wr_q   <= ahb_if.hwrite;
         end
      end
   end

   assign ahb_if.hready = rdy;
   assign ahb_if.hresp  =
      (!rst && (state_q == ST_ERR1 || state_q == ST_ERR2)) ?
      HRESP_ERROR : HRESP_OKAY;
   assign ahb_if.hrdata =
      (!rst && state_q == ST_LAST && !wr_q) ? rd_data : '0;

endmodule
